uart_tx_framer: RTL and testbench
=================================

# uart_tx_framer

Transmit-side framer for the waveform-generator UART link: it serialises one parameter frame into a byte stream for the UART TX core. The frame format matches the one the host-command parser accepts: `'s'`, signal number, adder, amplitude, `'e'`. The block sits between the waveform-control logic, which requests a readback or echo of the active settings, and the UART core's byte-wide valid/ready sink. It latches a snapshot of the payload on request, so the payload inputs may change freely during transmission.

## Interface
Parameters:
- `SOM`, default 8'h73 (`'s'`): start-of-message byte.
- `EOM`, default 8'h65 (`'e'`): end-of-message byte.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `send_req`  in  1: single-cycle request to transmit one frame; honoured only when `busy`=0.
- `signal_number`  in  8: payload byte 1; sampled when a request is accepted.
- `adder`  in  32: phase-accumulator increment; sampled when a request is accepted.
- `amplitude`  in  32: amplitude word; sampled when a request is accepted.
- `busy`  out  1: frame in progress; while high, `send_req` is ignored.
- `done`  out  1: one-cycle pulse after the EOM byte is transferred.
- `to_uart_data`  out  8: byte presented to the UART TX core.
- `to_uart_valid`  out  1: `to_uart_data` is valid.
- `to_uart_ready`  in  1: the UART core accepts the byte on this cycle.

## Operation
- Frame: 11 bytes, always in this order: `SOM`, `signal_number`, `adder[31:24]`, `adder[23:16]`, `adder[15:8]`, `adder[7:0]`, `amplitude[31:24]`, `amplitude[23:16]`, `amplitude[15:8]`, `amplitude[7:0]`, `EOM`. Multi-byte fields are sent MSB first.
- State machine:
  - `IDLE` → `SEND` on `send_req`. The request latches all three payload inputs into shadow registers and sets the byte index to 0.
  - `SEND` → `SEND` on each transfer (`to_uart_valid && to_uart_ready`) with index < 10; the index increments.
  - `SEND` → `IDLE` on the transfer with index = 10.
- Byte index: 4-bit counter, range 0..10. It never wraps; values 11..15 are unreachable, and if reached the block must return to `IDLE`.
- `to_uart_data` is a pure function of the byte index and the shadow registers. It is driven from a register, so it is stable for the whole time `to_uart_valid` is high.
- Handshake rules:
  - Once `to_uart_valid` is asserted, it stays high and `to_uart_data` stays constant until `to_uart_ready` is seen.
  - `to_uart_ready` may be low for any number of cycles, and may also be high before valid is asserted.
- `send_req` while `busy`=1 is dropped; there is no queueing.
- `send_req` arriving on the same cycle as `done` is accepted, giving back-to-back frames.
- The `done` pulse and `busy` falling occur together.
- Reset, including reset in the middle of a frame: the frame is aborted with no EOM sent. On the next edge the state is `IDLE`, index is 0, shadow registers are 0, and all outputs take their reset values.
- Reset values: `busy`=0, `done`=0, `to_uart_valid`=0, `to_uart_data`=8'h00.

## Timing
- Request accepted at edge N: `busy`=1 and `to_uart_valid`=1 with `to_uart_data`=`SOM` after edge N. First-byte latency is 1 cycle.
- Transfer at edge M: the next byte is presented after edge M, with no idle bubble.
- With `to_uart_ready` held high, the frame occupies exactly 11 cycles of valid.
- After the EOM transfer at edge K: `to_uart_valid`=0, `busy`=0 and `done`=1 after edge K, and `done`=0 after edge K+1 unless another frame completes.
- Minimum request-to-request spacing is 12 cycles (request, then 11 byte cycles).

## Structure
- Shared package `uart_frame_pkg`, also used by the receive-side parser:
  - `SOM` and `EOM` constants.
  - `FRAME_LEN` = 11.
  - Byte-index localparams: `IDX_SOM`=0, `IDX_SIG`=1, `IDX_ADD_HI`=2..`IDX_ADD_LO`=5, `IDX_AMP_HI`=6..`IDX_AMP_LO`=9, `IDX_EOM`=10.
- Optional sub-module `uart_frame_byte_sel`: combinational index → byte mux, reusable by a future loopback checker. The framer itself keeps the FSM, counter and shadow registers.

## Test plan
- Ready tied high: `send_req` with sig=8'h02, adder=32'h0003_46DC, amplitude=32'h0000_00FF → bytes 73 02 00 03 46 DC 00 00 00 FF 65 on 11 consecutive cycles; `done` pulses once, on the cycle after `65`.
- Random backpressure (ready at 30% duty): the same stream is produced; `to_uart_data` never changes while valid=1 and ready=0; no byte is dropped or duplicated.
- Payload inputs changed every cycle after the request → the transmitted bytes equal the values at the request cycle.
- `send_req` pulsed at bytes 3 and 7 of a frame → ignored: exactly one frame is sent. A `send_req` on the `done` cycle → a second frame starts on the next cycle with `SOM`.
- Reset asserted while byte 5 is presented → after that edge valid=0, busy=0, data=00. A following request sends a full frame starting with `SOM`.
- Ready high before the request and during idle → valid stays 0 and no byte is emitted until a request arrives.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: constants shared by the parameter-frame transmitter and receiver
package uart_frame_pkg;
    localparam logic [7:0] SOM = 8'h73;
    localparam logic [7:0] EOM = 8'h65;
    localparam int FRAME_LEN = 11;
    localparam logic [3:0] IDX_SOM    = 4'd0;
    localparam logic [3:0] IDX_SIG    = 4'd1;
    localparam logic [3:0] IDX_ADD_HI = 4'd2;
    localparam logic [3:0] IDX_ADD_2  = 4'd3;
    localparam logic [3:0] IDX_ADD_1  = 4'd4;
    localparam logic [3:0] IDX_ADD_LO = 4'd5;
    localparam logic [3:0] IDX_AMP_HI = 4'd6;
    localparam logic [3:0] IDX_AMP_2  = 4'd7;
    localparam logic [3:0] IDX_AMP_1  = 4'd8;
    localparam logic [3:0] IDX_AMP_LO = 4'd9;
    localparam logic [3:0] IDX_EOM    = 4'd10;
    typedef enum logic {IDLE, SEND} tx_state_t;
endpackage

// File: rtl/uart_frame_byte_sel.sv
// uart_frame_byte_sel: maps a frame byte index onto the corresponding frame byte
module uart_frame_byte_sel #(
    parameter logic [7:0] SOM_BYTE = uart_frame_pkg::SOM,
    parameter logic [7:0] EOM_BYTE = uart_frame_pkg::EOM
) (
    input  logic [3:0]  idx,
    input  logic [7:0]  sig,
    input  logic [31:0] adder,
    input  logic [31:0] amplitude,
    output logic [7:0]  data
);
    import uart_frame_pkg::*;
    always_comb begin
        data = 8'h00;
        case (idx)
            IDX_SOM:    data = SOM_BYTE;
            IDX_SIG:    data = sig;
            IDX_ADD_HI: data = adder[31:24];
            IDX_ADD_2:  data = adder[23:16];
            IDX_ADD_1:  data = adder[15:8];
            IDX_ADD_LO: data = adder[7:0];
            IDX_AMP_HI: data = amplitude[31:24];
            IDX_AMP_2:  data = amplitude[23:16];
            IDX_AMP_1:  data = amplitude[15:8];
            IDX_AMP_LO: data = amplitude[7:0];
            IDX_EOM:    data = EOM_BYTE;
            default:    data = 8'h00;
        endcase
    end
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises a latched parameter frame onto a byte-wide valid/ready sink
module uart_tx_framer #(
    parameter logic [7:0] SOM = uart_frame_pkg::SOM,
    parameter logic [7:0] EOM = uart_frame_pkg::EOM
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_req,
    input  logic [7:0]  signal_number,
    input  logic [31:0] adder,
    input  logic [31:0] amplitude,
    output logic        busy,
    output logic        done,
    output logic [7:0]  to_uart_data,
    output logic        to_uart_valid,
    input  logic        to_uart_ready
);
    import uart_frame_pkg::*;
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
    tx_state_t   state;
    logic [3:0]  idx;
    logic [3:0]  nxt_idx;
    logic [7:0]  sig_q;
    logic [31:0] add_q;
    logic [31:0] amp_q;
    logic [7:0]  nxt_data;
    logic        xfer;
    logic        fin;
    assign xfer    = to_uart_valid && to_uart_ready;
    assign nxt_idx = idx + 4'd1;
    // indices past LAST_IDX are unreachable; treat them as an abort back to IDLE
    assign fin     = (idx > LAST_IDX) || (xfer && idx == LAST_IDX);
    // the byte for the following index is looked up ahead so it can be registered
    uart_frame_byte_sel #(.SOM_BYTE(SOM), .EOM_BYTE(EOM)) u_sel (
        .idx      (nxt_idx),
        .sig      (sig_q),
        .adder    (add_q),
        .amplitude(amp_q),
        .data     (nxt_data)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            sig_q         <= '0;
            add_q         <= '0;
            amp_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            to_uart_valid <= 1'b0;
            to_uart_data  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (send_req) begin
                    state         <= SEND;
                    idx           <= '0;
                    sig_q         <= signal_number;
                    add_q         <= adder;
                    amp_q         <= amplitude;
                    busy          <= 1'b1;
                    to_uart_valid <= 1'b1;
                    to_uart_data  <= SOM;
                end
                SEND: if (fin) begin
                    state         <= IDLE;
                    idx           <= '0;
                    busy          <= 1'b0;
                    done          <= xfer && idx == LAST_IDX;
                    to_uart_valid <= 1'b0;
                    to_uart_data  <= 8'h00;
                end else if (xfer) begin
                    idx          <= nxt_idx;
                    to_uart_data <= nxt_data;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: table-driven frame vectors with a byte scoreboard plus corner-case sequences
module tb_uart_tx_framer;
    logic        clk = 1'b0;
    logic        reset;
    logic        send_req;
    logic [7:0]  signal_number;
    logic [31:0] adder;
    logic [31:0] amplitude;
    logic        busy;
    logic        done;
    logic [7:0]  to_uart_data;
    logic        to_uart_valid;
    logic        to_uart_ready;

    always #5 clk = ~clk;

    uart_tx_framer dut (
        .clk          (clk),
        .reset        (reset),
        .send_req     (send_req),
        .signal_number(signal_number),
        .adder        (adder),
        .amplitude    (amplitude),
        .busy         (busy),
        .done         (done),
        .to_uart_data (to_uart_data),
        .to_uart_valid(to_uart_valid),
        .to_uart_ready(to_uart_ready)
    );

    typedef struct {
        logic [7:0]  sig;
        logic [31:0] add;
        logic [31:0] amp;
        int          ready_pct;
        bit          scramble;
        logic [87:0] exp;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] sb [$];
    int         checks = 0;
    int         fails = 0;
    int         ready_pct = 100;
    int         dones = 0;
    bit         scramble = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [87:0] f);
        for (int i = 10; i >= 0; i--) sb.push_back(f[i*8 +: 8]);
    endtask

    // one clock: drive ready/payload, then score whatever the edge transferred
    task automatic tick();
        logic v, r;
        logic [7:0] d;
        to_uart_ready = ($urandom_range(99) < ready_pct);
        if (scramble) begin
            signal_number = 8'($urandom);
            adder         = $urandom;
            amplitude     = $urandom;
        end
        v = to_uart_valid;
        r = to_uart_ready;
        d = to_uart_data;
        @(posedge clk);
        #1;
        if (v && r) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_byte: got %h expected none", d);
            end else begin
                check("byte", {24'h0, d}, {24'h0, sb.pop_front()});
            end
        end else if (v) begin
            check("hold_valid", {31'h0, to_uart_valid}, 32'h1);
            check("hold_data", {24'h0, to_uart_data}, {24'h0, d});
        end
        if (done) dones++;
    endtask

    task automatic request(input vec_t v);
        signal_number = v.sig;
        adder         = v.add;
        amplitude     = v.amp;
        send_req      = 1'b1;
        push_frame(v.exp);
        tick();
        send_req = 1'b0;
        check("busy_after_req", {31'h0, busy}, 32'h1);
        check("first_byte_som", {23'h0, to_uart_valid, to_uart_data}, {23'h0, 1'b1, 8'h73});
    endtask

    task automatic wait_done(output int cyc);
        cyc   = 0;
        dones = 0;
        while (dones == 0 && cyc < 2000) begin
            tick();
            cyc++;
        end
        if (dones == 0) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 2000 cycles");
        end
    endtask

    initial begin
        int cyc;
        vecs[0] = '{8'h02, 32'h0003_46DC, 32'h0000_00FF, 100, 1'b0, 88'h73_02_00_03_46_DC_00_00_00_FF_65};
        vecs[1] = '{8'h02, 32'h0003_46DC, 32'h0000_00FF, 30,  1'b0, 88'h73_02_00_03_46_DC_00_00_00_FF_65};
        vecs[2] = '{8'hA5, 32'hDEAD_BEEF, 32'h1234_5678, 50,  1'b1, 88'h73_A5_DE_AD_BE_EF_12_34_56_78_65};
        vecs[3] = '{8'hFF, 32'h8000_0001, 32'hFFFF_FFFF, 100, 1'b1, 88'h73_FF_80_00_00_01_FF_FF_FF_FF_65};
        vecs[4] = '{8'h00, 32'h0000_0000, 32'h0000_0000, 20,  1'b0, 88'h73_00_00_00_00_00_00_00_00_00_65};
        reset = 1'b1;
        send_req = 1'b0;
        to_uart_ready = 1'b0;
        signal_number = 8'h0;
        adder = 32'h0;
        amplitude = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_valid", {31'h0, to_uart_valid}, 32'h0);
        check("reset_data", {24'h0, to_uart_data}, 32'h0);
        reset = 1'b0;
        // ready high while idle must not produce bytes
        ready_pct = 100;
        repeat (6) tick();
        check("idle_valid", {31'h0, to_uart_valid}, 32'h0);
        check("idle_busy", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            ready_pct = vecs[i].ready_pct;
            request(vecs[i]);
            scramble = vecs[i].scramble;
            wait_done(cyc);
            scramble = 1'b0;
            check("frame_sb_empty", sb.size(), 32'h0);
            check("done_busy_low", {30'h0, busy, to_uart_valid}, 32'h0);
            if (vecs[i].ready_pct == 100) check("frame_cycles", cyc, 32'd11);
            tick();
            check("done_one_pulse", {31'h0, done}, 32'h0);
        end
        // requests at bytes 3 and 7 are dropped
        ready_pct = 100;
        request(vecs[0]);
        dones = 0;
        for (int k = 1; k <= 26; k++) begin
            send_req = (k == 3 || k == 7);
            tick();
            send_req = 1'b0;
        end
        check("ignored_req_dones", dones, 32'd1);
        check("ignored_req_sb", sb.size(), 32'h0);
        check("ignored_req_idle", {31'h0, to_uart_valid}, 32'h0);
        // request on the done cycle starts a back-to-back frame
        request(vecs[2]);
        wait_done(cyc);
        send_req = 1'b1;
        push_frame(vecs[0].exp);
        signal_number = vecs[0].sig;
        adder = vecs[0].add;
        amplitude = vecs[0].amp;
        tick();
        send_req = 1'b0;
        check("b2b_som", {23'h0, to_uart_valid, to_uart_data}, {23'h0, 1'b1, 8'h73});
        wait_done(cyc);
        check("b2b_cycles", cyc, 32'd11);
        check("b2b_sb_empty", sb.size(), 32'h0);
        // reset while byte 5 is presented aborts the frame
        request(vecs[3]);
        repeat (5) tick();
        check("pre_reset_byte5", {24'h0, to_uart_data}, {24'h0, sb[0]});
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_valid", {31'h0, to_uart_valid}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_data", {24'h0, to_uart_data}, 32'h0);
        sb.delete();
        ready_pct = 60;
        request(vecs[0]);
        wait_done(cyc);
        check("post_reset_sb_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
